// File: rtl/inst_fetch_if.sv
// Control and program-counter signals between the decoder/ALU side and the fetch stage.
interface inst_fetch_if #(
    parameter int unsigned PC_WIDTH = 10
);
    logic                Start;
    logic                BranchEn;
    logic                BranchOnFlag;
    logic                branch_flag;
    logic [PC_WIDTH-1:0] Target;
    logic [PC_WIDTH-1:0] ProgCtr;

    modport master (
        output Start,
        output BranchEn,
        output BranchOnFlag,
        output branch_flag,
        output Target,
        input  ProgCtr
    );

    modport slave (
        input  Start,
        input  BranchEn,
        input  BranchOnFlag,
        input  branch_flag,
        input  Target,
        output ProgCtr
    );
endinterface

// File: rtl/inst_fetch.sv
// Program counter with hold, increment and absolute branch selection.
// ProgCtr is purely registered; every input acts on the following rising edge.
module inst_fetch #(
    parameter int unsigned                 PC_WIDTH     = 10,
    parameter logic [PC_WIDTH-1:0]         RESET_VECTOR = '0
) (
    input  logic       Clk,
    input  logic       Reset,
    inst_fetch_if.slave bus
);

    logic [PC_WIDTH-1:0] prog_ctr_q;
    logic [PC_WIDTH-1:0] prog_ctr_d;
    logic                take_branch_c;

    // Conditional branches need the ALU flag; unconditional ones ignore it.
    always_comb begin
        take_branch_c = bus.BranchEn & (~bus.BranchOnFlag | bus.branch_flag);
        prog_ctr_d    = prog_ctr_q;
        if (bus.Start) begin
            prog_ctr_d = prog_ctr_q;
        end else if (take_branch_c) begin
            prog_ctr_d = bus.Target;
        end else begin
            prog_ctr_d = prog_ctr_q + PC_WIDTH'(1);
        end
    end

    // Reset wins over hold and branch on the same edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prog_ctr_q <= RESET_VECTOR;
        end else begin
            prog_ctr_q <= prog_ctr_d;
        end
    end

    assign bus.ProgCtr = prog_ctr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plan plus randomized traffic against an arithmetic PC reference model.
module tb_inst_fetch;

    localparam int unsigned PC_W  = 10;
    localparam int          PC_MOD = 1 << PC_W;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_pc;

    inst_fetch_if #(.PC_WIDTH(PC_W)) bus ();

    inst_fetch #(.PC_WIDTH(PC_W), .RESET_VECTOR('0)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [PC_W-1:0] got, input logic [PC_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive on the falling edge, update the model, sample 1ns after the rising edge.
    task automatic step(input string tag, input bit rst, input bit start, input bit be,
                        input bit bof, input bit bf, input int tgt);
        @(negedge clk);
        rst_n            = rst;
        bus.Start        = start;
        bus.BranchEn     = be;
        bus.BranchOnFlag = bof;
        bus.branch_flag  = bf;
        bus.Target       = PC_W'(tgt);
        if (!rst)                     exp_pc = 0;
        else if (start)               exp_pc = exp_pc;
        else if (be && (!bof || bf))  exp_pc = tgt % PC_MOD;
        else                          exp_pc = (exp_pc + 1) % PC_MOD;
        @(posedge clk);
        #1;
        check_eq(tag, bus.ProgCtr, PC_W'(exp_pc));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_pc  = 0;
        rst_n            = 1'b0;
        bus.Start        = 1'b0;
        bus.BranchEn     = 1'b0;
        bus.BranchOnFlag = 1'b0;
        bus.branch_flag  = 1'b0;
        bus.Target       = '0;

        // Reset held for two edges
        for (int i = 0; i < 2; i++) step("reset", 0, 0, 0, 0, 0, 0);
        check_eq("reset_const", bus.ProgCtr, PC_W'(0));

        // Count 1..10
        for (int i = 0; i < 10; i++) step("count", 1, 0, 0, 0, 0, 0);
        check_eq("count_to_10", bus.ProgCtr, PC_W'(10));

        // Hold ignores a pending taken branch
        for (int i = 0; i < 5; i++) step("hold", 1, 1, 1, 0, 1, 500);
        check_eq("hold_10", bus.ProgCtr, PC_W'(10));
        step("resume", 1, 0, 0, 0, 0, 0);
        check_eq("resume_11", bus.ProgCtr, PC_W'(11));

        // Conditional branch taken, then not taken
        step("cond_taken", 1, 0, 1, 1, 1, 1000);
        check_eq("cond_1000", bus.ProgCtr, PC_W'(1000));
        for (int i = 0; i < 5; i++) step("cond_not_taken", 1, 0, 1, 1, 0, 300);
        check_eq("cond_1005", bus.ProgCtr, PC_W'(1005));

        // Unconditional branch and wrap past the top
        step("uncond", 1, 0, 1, 0, 0, 42);
        check_eq("uncond_42", bus.ProgCtr, PC_W'(42));
        step("to_top", 1, 0, 1, 0, 0, 1023);
        step("wrap", 1, 0, 0, 0, 0, 0);
        check_eq("wrap_0", bus.ProgCtr, PC_W'(0));

        // Reset overrides hold and branch together
        step("to_37", 1, 0, 1, 0, 0, 37);
        step("reset_override", 0, 1, 1, 0, 1, 777);
        check_eq("reset_override_0", bus.ProgCtr, PC_W'(0));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, s, be, bof, bf;
            int t;
            r   = ($urandom_range(31) != 0);
            s   = ($urandom_range(3) == 0);
            be  = $urandom_range(1);
            bof = $urandom_range(1);
            bf  = $urandom_range(1);
            t   = ($urandom_range(7) == 0) ? int'($urandom_range(1023, 1018)) : int'($urandom_range(1023));
            step("random", r, s, be, bof, bf, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
